// File: rtl/reservation_station_mc.sv
// Reservation station with CDB wakeup, same-cycle take bypass and single-entry dispatch.
// Optional macro RS_OLDEST_FIRST_EN: dispatch the oldest ready entry (age matrix);
// when undefined, the lowest-index ready entry is dispatched and no age state exists.

package reservation_station_mc_pkg;
  typedef struct packed {
    logic       is_sub;
    logic [3:0] alu_fn;
  } add_sub_decode_t;
endpackage

module reservation_station_mc
  import reservation_station_mc_pkg::*;
#(
  parameter int unsigned OPERANDS     = 2,
  parameter int unsigned RS_OFFSET    = 0,
  parameter int unsigned RS_DEPTH     = 8,
  parameter int unsigned RS_ID_WIDTH  = 5,
  parameter int unsigned CDB_PORTS    = 2,
  parameter type         CONTROL_TYPE = add_sub_decode_t
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  take_valid,
  output logic                                  take_ready,
  input  logic [OPERANDS-1:0]                   op_value_valid_in,
  input  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]  op_rs_id_in,
  input  logic [OPERANDS-1:0][31:0]             op_value_in,
  input  CONTROL_TYPE                           control_in,
  output logic [RS_ID_WIDTH-1:0]                id_taken,
  input  logic [CDB_PORTS-1:0]                  cdb_valid,
  input  logic [CDB_PORTS-1:0][RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [CDB_PORTS-1:0][31:0]            cdb_value,
  input  logic                                  flush,
  output logic                                  output_valid,
  input  logic                                  output_ready,
  output logic [OPERANDS-1:0][31:0]             op_value_out,
  output CONTROL_TYPE                           control_out,
  output logic [RS_ID_WIDTH-1:0]                op_rs_id_out,
  output logic [$clog2(RS_DEPTH+1)-1:0]         occupancy
);

  localparam int unsigned IdxW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int unsigned OccW = $clog2(RS_DEPTH + 1);

  // Entry state
  logic [RS_DEPTH-1:0]                                r_valid, w_valid_nxt;
  logic [RS_DEPTH-1:0][OPERANDS-1:0]                  r_opv, w_opv_nxt;
  logic [RS_DEPTH-1:0][OPERANDS-1:0][RS_ID_WIDTH-1:0] r_tag, w_tag_nxt;
  logic [RS_DEPTH-1:0][OPERANDS-1:0][31:0]            r_val, w_val_nxt;
  CONTROL_TYPE                                        r_ctrl [RS_DEPTH];
  CONTROL_TYPE                                        w_ctrl_nxt [RS_DEPTH];
  logic [OccW-1:0]                                    r_occ, w_occ_nxt;

  logic [RS_DEPTH-1:0] w_ready;
  logic [IdxW-1:0]     w_take_idx;
  logic [IdxW-1:0]     w_sel_idx;
  logic                w_take_fire;
  logic                w_disp_fire;

  // Lowest free slot; take_ready depends only on registered valid bits
  always_comb begin
    w_take_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_take_idx = IdxW'(i);
    end
  end

  assign take_ready = ~&r_valid;
  assign id_taken   = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(w_take_idx);

  // An entry is ready once every operand has its value
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_ready[i] = r_valid[i] & (&r_opv[i]);
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // r_older[a][b] = 1 means entry a was allocated before entry b
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] r_older;
  logic [RS_DEPTH-1:0]               w_blocked;

  // Age matrix: a new entry is younger than everything present
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_older <= '0;
    end else if (w_take_fire) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        r_older[w_take_idx][j] <= 1'b0;
        r_older[j][w_take_idx] <= (IdxW'(j) != w_take_idx);
      end
    end
  end

  // Select the ready entry that no other ready entry predates
  always_comb begin
    w_blocked = '0;
    w_sel_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (j != i && w_ready[j] && r_older[j][i]) w_blocked[i] = 1'b1;
      end
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (w_ready[i] && !w_blocked[i]) w_sel_idx = IdxW'(i);
    end
  end
`else
  // Select the lowest-index ready entry
  always_comb begin
    w_sel_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (w_ready[i]) w_sel_idx = IdxW'(i);
    end
  end
`endif

  assign output_valid = (|w_ready) & ~flush;
  assign w_disp_fire  = output_valid & output_ready;
  assign w_take_fire  = take_valid & take_ready & ~flush;
  assign op_value_out = r_val[w_sel_idx];
  assign control_out  = r_ctrl[w_sel_idx];
  assign op_rs_id_out = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(w_sel_idx);
  assign occupancy    = r_occ;

  // Next entry state: wakeup, dispatch clear, take with bypass, flush last
  always_comb begin
    w_valid_nxt = r_valid;
    w_opv_nxt   = r_opv;
    w_tag_nxt   = r_tag;
    w_val_nxt   = r_val;
    w_ctrl_nxt  = r_ctrl;

    // Ports scanned high to low so the lowest matching port lands last
    for (int e = 0; e < RS_DEPTH; e++) begin
      for (int o = 0; o < OPERANDS; o++) begin
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
          if (r_valid[e] && !r_opv[e][o] && cdb_valid[p] && cdb_rs_id[p] == r_tag[e][o]) begin
            w_opv_nxt[e][o] = 1'b1;
            w_val_nxt[e][o] = cdb_value[p];
          end
        end
      end
    end

    if (w_disp_fire) w_valid_nxt[w_sel_idx] = 1'b0;

    // Take slot is invalid in registered state, so it never aliases the dispatched one
    if (w_take_fire) begin
      w_valid_nxt[w_take_idx] = 1'b1;
      w_ctrl_nxt[w_take_idx]  = control_in;
      for (int o = 0; o < OPERANDS; o++) begin
        w_tag_nxt[w_take_idx][o] = op_rs_id_in[o];
        w_opv_nxt[w_take_idx][o] = op_value_valid_in[o];
        w_val_nxt[w_take_idx][o] = op_value_in[o];
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
          if (!op_value_valid_in[o] && cdb_valid[p] && cdb_rs_id[p] == op_rs_id_in[o]) begin
            w_opv_nxt[w_take_idx][o] = 1'b1;
            w_val_nxt[w_take_idx][o] = cdb_value[p];
          end
        end
      end
    end

    if (flush) w_valid_nxt = '0;
  end

  // Occupancy tracks +take -dispatch; both in one cycle cancel
  always_comb begin
    w_occ_nxt = r_occ;
    if (flush) begin
      w_occ_nxt = '0;
    end else if (w_take_fire && !w_disp_fire) begin
      w_occ_nxt = r_occ + OccW'(1);
    end else if (!w_take_fire && w_disp_fire) begin
      w_occ_nxt = r_occ - OccW'(1);
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_opv   <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_opv   <= w_opv_nxt;
      r_occ   <= w_occ_nxt;
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    r_tag  <= w_tag_nxt;
    r_val  <= w_val_nxt;
    r_ctrl <= w_ctrl_nxt;
  end

endmodule

// File: tb/tb_reservation_station_mc.sv
// Directed bench for reservation_station_mc (RS_DEPTH=4, OPERANDS=2, CDB_PORTS=2, RS_OFFSET=8).
module tb_reservation_station_mc;
  import reservation_station_mc_pkg::*;

  localparam int unsigned Ops    = 2;
  localparam int unsigned Depth  = 4;
  localparam int unsigned IdW    = 5;
  localparam int unsigned Cdb    = 2;
  localparam int unsigned Offset = 8;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          take_valid;
  logic                          take_ready;
  logic [Ops-1:0]                op_value_valid_in;
  logic [Ops-1:0][IdW-1:0]       op_rs_id_in;
  logic [Ops-1:0][31:0]          op_value_in;
  add_sub_decode_t               control_in;
  logic [IdW-1:0]                id_taken;
  logic [Cdb-1:0]                cdb_valid;
  logic [Cdb-1:0][IdW-1:0]       cdb_rs_id;
  logic [Cdb-1:0][31:0]          cdb_value;
  logic                          flush;
  logic                          output_valid;
  logic                          output_ready;
  logic [Ops-1:0][31:0]          op_value_out;
  add_sub_decode_t               control_out;
  logic [IdW-1:0]                op_rs_id_out;
  logic [$clog2(Depth+1)-1:0]    occupancy;

  int checks   = 0;
  int failures = 0;
  int exp_first;
  int exp_second;

  reservation_station_mc #(
    .OPERANDS   (Ops),
    .RS_OFFSET  (Offset),
    .RS_DEPTH   (Depth),
    .RS_ID_WIDTH(IdW),
    .CDB_PORTS  (Cdb)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .take_valid       (take_valid),
    .take_ready       (take_ready),
    .op_value_valid_in(op_value_valid_in),
    .op_rs_id_in      (op_rs_id_in),
    .op_value_in      (op_value_in),
    .control_in       (control_in),
    .id_taken         (id_taken),
    .cdb_valid        (cdb_valid),
    .cdb_rs_id        (cdb_rs_id),
    .cdb_value        (cdb_value),
    .flush            (flush),
    .output_valid     (output_valid),
    .output_ready     (output_ready),
    .op_value_out     (op_value_out),
    .control_out      (control_out),
    .op_rs_id_out     (op_rs_id_out),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    take_valid        = 1'b0;
    op_value_valid_in = '0;
    op_rs_id_in       = '0;
    op_value_in       = '0;
    control_in        = '0;
    cdb_valid         = '0;
    cdb_rs_id         = '0;
    cdb_value         = '0;
    flush             = 1'b0;
    output_ready      = 1'b0;
  endtask

  task automatic take(input logic [1:0] vld, input logic [IdW-1:0] t0, input logic [IdW-1:0] t1,
                      input logic [31:0] v0, input logic [31:0] v1, input logic [3:0] fn);
    take_valid        = 1'b1;
    op_value_valid_in = vld;
    op_rs_id_in[0]    = t0;
    op_rs_id_in[1]    = t1;
    op_value_in[0]    = v0;
    op_value_in[1]    = v1;
    control_in.is_sub = fn[0];
    control_in.alu_fn = fn;
  endtask

  initial begin
`ifdef RS_OLDEST_FIRST_EN
    exp_first  = 9;
    exp_second = 8;
`else
    exp_first  = 8;
    exp_second = 9;
`endif
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_take_ready", 32'(take_ready), 1);
    chk("rst_id_taken", 32'(id_taken), 8);
    chk("rst_output_valid", 32'(output_valid), 0);
    chk("rst_op_rs_id_out", 32'(op_rs_id_out), 8);
    chk("rst_occupancy", 32'(occupancy), 0);

    // Four takes fill the station
    for (int i = 0; i < 4; i++) begin
      take(2'b11, '0, '0, 32'h100 + i, 32'h200 + i, 4'(i));
      #1;
      chk($sformatf("fill_id_taken%0d", i), 32'(id_taken), 32'(8 + i));
      chk($sformatf("fill_take_ready%0d", i), 32'(take_ready), 1);
      tick();
    end
    idle();
    #1;
    chk("full_take_ready", 32'(take_ready), 0);
    chk("full_occupancy", 32'(occupancy), 4);
    chk("full_output_valid", 32'(output_valid), 1);
    chk("full_op_rs_id_out", 32'(op_rs_id_out), 8);
    chk("full_op0", op_value_out[0], 32'h100);
    chk("full_op1", op_value_out[1], 32'h200);
    chk("full_ctrl", 32'(control_out.alu_fn), 0);

    // Full: take refused while dispatch completes
    take(2'b11, '0, '0, 32'h999, 32'h999, 4'h9);
    output_ready = 1'b1;
    #1;
    chk("fulldisp_take_ready", 32'(take_ready), 0);
    tick();
    idle();
    #1;
    chk("fulldisp_occupancy", 32'(occupancy), 3);
    chk("fulldisp_take_ready_after", 32'(take_ready), 1);
    chk("fulldisp_id_taken", 32'(id_taken), 8);
    chk("fulldisp_op_rs_id_out", 32'(op_rs_id_out), 9);

    // Flush with three entries present
    flush = 1'b1;
    #1;
    chk("flush_output_valid_during", 32'(output_valid), 0);
    tick();
    idle();
    #1;
    chk("flush_occupancy", 32'(occupancy), 0);
    chk("flush_output_valid", 32'(output_valid), 0);
    chk("flush_take_ready", 32'(take_ready), 1);
    chk("flush_id_taken", 32'(id_taken), 8);

    // Wakeup on cdb port 1, one cycle after take
    take(2'b10, 5'd3, '0, 32'h0, 32'h55, 4'h1);
    tick();
    idle();
    cdb_valid[1] = 1'b1;
    cdb_rs_id[1] = 5'd3;
    cdb_value[1] = 32'hDEADBEEF;
    #1;
    chk("wake_not_ready_yet", 32'(output_valid), 0);
    tick();
    idle();
    #1;
    chk("wake_output_valid", 32'(output_valid), 1);
    chk("wake_op0", op_value_out[0], 32'hDEADBEEF);
    chk("wake_op1", op_value_out[1], 32'h55);
    output_ready = 1'b1;
    tick();
    idle();
    #1;
    chk("wake_drain_occupancy", 32'(occupancy), 0);

    // Same-cycle bypass, both ports matching: port 0 wins
    take(2'b01, '0, 5'd5, 32'h77, 32'h0, 4'h2);
    cdb_valid    = 2'b11;
    cdb_rs_id[0] = 5'd5;
    cdb_value[0] = 32'h00001234;
    cdb_rs_id[1] = 5'd5;
    cdb_value[1] = 32'h00009999;
    tick();
    idle();
    #1;
    chk("bypass_output_valid", 32'(output_valid), 1);
    chk("bypass_op1", op_value_out[1], 32'h00001234);
    chk("bypass_op0", op_value_out[0], 32'h77);
    output_ready = 1'b1;
    tick();
    idle();

    // Non-matching tag leaves operand pending; dual-port wakeup picks port 0
    take(2'b10, 5'd6, '0, 32'h0, 32'h1, 4'h3);
    tick();
    idle();
    cdb_valid[0] = 1'b1;
    cdb_rs_id[0] = 5'd7;
    cdb_value[0] = 32'hFFFF;
    tick();
    idle();
    #1;
    chk("nomatch_output_valid", 32'(output_valid), 0);
    cdb_valid    = 2'b11;
    cdb_rs_id[0] = 5'd6;
    cdb_value[0] = 32'hAAAA;
    cdb_rs_id[1] = 5'd6;
    cdb_value[1] = 32'hBBBB;
    tick();
    idle();
    #1;
    chk("prio_output_valid", 32'(output_valid), 1);
    chk("prio_op0", op_value_out[0], 32'hAAAA);
    output_ready = 1'b1;
    tick();
    idle();

    // Selection order after slot 0 is reused
    take(2'b11, '0, '0, 32'hA0, 32'hA1, 4'h4);
    tick();
    take(2'b11, '0, '0, 32'hB0, 32'hB1, 4'h5);
    tick();
    idle();
    output_ready = 1'b1;
    #1;
    chk("age_first_disp", 32'(op_rs_id_out), 8);
    tick();
    idle();
    take(2'b11, '0, '0, 32'hC0, 32'hC1, 4'h6);
    #1;
    chk("age_realloc_id", 32'(id_taken), 8);
    tick();
    idle();
    #1;
    chk("age_occupancy", 32'(occupancy), 2);
    chk("age_sel_first", 32'(op_rs_id_out), 32'(exp_first));
    output_ready = 1'b1;
    tick();
    #1;
    chk("age_sel_second", 32'(op_rs_id_out), 32'(exp_second));
    tick();
    idle();
    #1;
    chk("age_drain_occupancy", 32'(occupancy), 0);
    chk("age_drain_output_valid", 32'(output_valid), 0);

    // Take and dispatch in the same cycle: net occupancy unchanged
    take(2'b11, '0, '0, 32'hD0, 32'hD1, 4'h7);
    tick();
    take(2'b11, '0, '0, 32'hE0, 32'hE1, 4'h8);
    output_ready = 1'b1;
    #1;
    chk("td_id_taken", 32'(id_taken), 9);
    chk("td_op_rs_id_out", 32'(op_rs_id_out), 8);
    tick();
    idle();
    #1;
    chk("td_occupancy", 32'(occupancy), 1);
    chk("td_remaining", 32'(op_rs_id_out), 9);
    chk("td_remaining_op0", op_value_out[0], 32'hE0);

    // Reset overrides take and dispatch
    take(2'b11, '0, '0, 32'hF0, 32'hF1, 4'h9);
    output_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("midrst_occupancy", 32'(occupancy), 0);
    chk("midrst_output_valid", 32'(output_valid), 0);
    chk("midrst_take_ready", 32'(take_ready), 1);
    chk("midrst_id_taken", 32'(id_taken), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
